// File: rtl/led_pkg.sv
// led_pkg: shared constants and arbiter state type for the pixel memory arbiter.
//   PIXEL_W_DEF     default bits per pixel (GRB)
//   NUM_PIXELS_DEF  default pixels per frame-buffer bank
//   STARVE_MAX_DEF  default read-grant streak allowed while a write waits
//   ADDR_W          pixel index width; memory address is {bank, index}
package led_pkg;
   localparam int PIXEL_W_DEF    = 24;
   localparam int NUM_PIXELS_DEF = 64;
   localparam int STARVE_MAX_DEF = 4;
   localparam int ADDR_W         = 6;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } arb_state_t;
   function automatic logic pix_in_range(input logic [ADDR_W-1:0] idx, input int num_pixels);
      return int'(idx) < num_pixels;
   endfunction
endpackage

// File: rtl/arb_starve_guard.sv
// arb_starve_guard: counts consecutive read grants made while a write waits and
// forces the next contested grant to the write once the streak hits STARVE_MAX.
//   clk, rst      clock, asynchronous active-high reset
//   wr_req        write request currently pending
//   rd_grant      a read is being granted this cycle
//   wr_grant      a write is being granted this cycle
//   force_write   streak exhausted; the write must win the next contest
module arb_starve_guard
   import led_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic wr_req,
   input  logic rd_grant,
   input  logic wr_grant,
   output logic force_write
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign force_write = cnt_q == CW'(STARVE_MAX);
   always_comb begin
      cnt_d = (!wr_req || wr_grant) ? '0 : (rd_grant && !force_write) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter: arbitrates display reads and pattern writes onto one
// single-port RAM holding two frame banks, and swaps banks at frame boundaries.
//   clk, rst                 clock, asynchronous active-high reset
//   rd_req/rd_addr           read of the front bank; rd_ack grant pulse
//   rd_valid/rd_data         read result, one cycle after rd_ack
//   wr_req/wr_addr/wr_data   write into the back bank; wr_ack grant pulse
//   wr_commit                back bank complete, swap at next frame_done
//   frame_done               display finished a frame
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port, 1-cycle read latency
//   front_bank               bank being displayed
// Build option: ARB_STARVE_GUARD_EN adds write anti-starvation; otherwise reads
// always win contested cycles.
module pixel_mem_arbiter
   import led_pkg::*;
#(
   parameter int NUM_PIXELS = NUM_PIXELS_DEF,
   parameter int PIXEL_W    = PIXEL_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_req,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic               rd_ack,
   output logic               rd_valid,
   output logic [PIXEL_W-1:0] rd_data,
   input  logic               wr_req,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [PIXEL_W-1:0] wr_data,
   output logic               wr_ack,
   input  logic               wr_commit,
   input  logic               frame_done,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W:0]    mem_addr,
   output logic [PIXEL_W-1:0] mem_wdata,
   input  logic [PIXEL_W-1:0] mem_rdata,
   output logic               front_bank
);
   arb_state_t state_q, state_d;
   logic front_bank_q, front_bank_d;
   logic swap_pending_q, swap_pending_d;
   logic rd_valid_q, rd_valid_d;
   logic rd_oob_q, rd_oob_d;
   logic force_write, wr_wins, swap, rd_ok, wr_ok;
`ifdef ARB_STARVE_GUARD_EN
   arb_starve_guard #(.STARVE_MAX(STARVE_MAX)) u_starve_guard (
      .clk         (clk),
      .rst         (rst),
      .wr_req      (wr_req),
      .rd_grant    (state_d == RD),
      .wr_grant    (state_d == WR),
      .force_write (force_write)
   );
`else
   // Strict read priority; STARVE_MAX only matters with the guard built in.
   assign force_write = STARVE_MAX < 0;
`endif
   assign rd_ok = pix_in_range(rd_addr, NUM_PIXELS);
   assign wr_ok = pix_in_range(wr_addr, NUM_PIXELS);
   always_comb begin
      wr_wins        = wr_req && (!rd_req || force_write);
      state_d        = (rd_req && !wr_wins) ? RD : wr_wins ? WR : IDLE;
      swap           = frame_done && (swap_pending_q || wr_commit);
      front_bank_d   = front_bank_q ^ swap;
      // A commit arriving while one is already pending folds into the same swap.
      swap_pending_d = !swap && (swap_pending_q || wr_commit);
      rd_valid_d     = state_q == RD;
      // Out-of-range reads still complete, but return zero instead of RAM data.
      rd_oob_d       = state_q == RD && !rd_ok;
   end
   // Grants use the bank as it stands during the grant cycle, so a read in the
   // swap cycle still addresses the pre-swap front bank.
   assign rd_ack     = state_q == RD;
   assign wr_ack     = state_q == WR;
   assign mem_we     = wr_ack && wr_ok;
   assign mem_en     = (rd_ack && rd_ok) || mem_we;
   assign mem_addr   = (rd_ack && rd_ok) ? {front_bank_q, rd_addr} : mem_we ? {~front_bank_q, wr_addr} : '0;
   assign mem_wdata  = mem_we ? wr_data : '0;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = (rd_valid_q && !rd_oob_q) ? mem_rdata : '0;
   assign front_bank = front_bank_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         front_bank_q   <= 1'b0;
         swap_pending_q <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_oob_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         front_bank_q   <= front_bank_d;
         swap_pending_q <= swap_pending_d;
         rd_valid_q     <= rd_valid_d;
         rd_oob_q       <= rd_oob_d;
      end
   end
endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// tb_pixel_mem_arbiter: directed scenarios plus randomized traffic against a
// per-cycle reference model of the arbiter and its two-bank memory.
module tb_pixel_mem_arbiter;
   localparam int NP = 64;
   localparam int SM = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic rd_req, rd_ack, rd_valid, wr_req, wr_ack, wr_commit, frame_done;
   logic mem_en, mem_we, front_bank;
   logic [5:0] rd_addr, wr_addr;
   logic [6:0] mem_addr;
   logic [23:0] rd_data, wr_data, mem_wdata, mem_rdata;
   logic [23:0] ram [128];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   pixel_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .wr_commit(wr_commit), .frame_done(frame_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .front_bank(front_bank)
   );
   function automatic logic [23:0] init_pix(input int i);
      return {8'(i), 8'(i * 7 + 3), 8'(255 - i)};
   endfunction
   // Single-port RAM with one-cycle read latency; port sampled mid-cycle.
   initial begin : ram_model
      logic en, we;
      logic [6:0] a;
      logic [23:0] wd;
      for (int i = 0; i < 128; i++) ram[i] = init_pix(i);
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         en = mem_en; we = mem_we; a = mem_addr; wd = mem_wdata;
         @(posedge clk);
         if (en) begin
            if (we) ram[a] = wd;
            else mem_rdata = ram[a];
         end
      end
   end
   task automatic idle_inputs();
      rd_req = 0; wr_req = 0; wr_commit = 0; frame_done = 0;
      rd_addr = 0; wr_addr = 0; wr_data = 0;
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 rd_req = 1; wr_req = 1; wr_data = 24'h123456; frame_done = 1; wr_commit = 1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rd_ack, wr_ack, rd_valid, mem_en, mem_we, front_bank} !== 6'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=000000", {rd_ack, wr_ack, rd_valid, mem_en, mem_we, front_bank});
      end
      checks++;
      if ({mem_addr, mem_wdata, rd_data} !== '0) begin
         failures++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp all 0", mem_addr, mem_wdata, rd_data);
      end
      idle_inputs();
      @(posedge clk); #1 rst = 0;
   endtask
   task automatic test_read();
      @(posedge clk); #1 rd_req = 1; rd_addr = 6'd5;
      @(posedge clk); #1 rd_req = 0;
      @(negedge clk);
      checks++;
      if ({rd_ack, wr_ack, mem_en, mem_we} !== 4'b1010) begin
         failures++; $display("FAIL read_grant got=%b exp=1010", {rd_ack, wr_ack, mem_en, mem_we});
      end
      checks++;
      if (mem_addr !== 7'd5) begin failures++; $display("FAIL read_addr got=%0d exp=5", mem_addr); end
      @(negedge clk);
      checks++;
      if ({rd_valid, rd_ack} !== 2'b10) begin failures++; $display("FAIL read_valid got=%b exp=10", {rd_valid, rd_ack}); end
      checks++;
      if (rd_data !== init_pix(5)) begin failures++; $display("FAIL read_data got=%h exp=%h", rd_data, init_pix(5)); end
   endtask
   task automatic test_write();
      @(posedge clk); #1 wr_req = 1; wr_addr = 6'd63; wr_data = 24'hFF0000;
      @(posedge clk); #1 wr_req = 0;
      @(negedge clk);
      checks++;
      if ({rd_ack, wr_ack, mem_en, mem_we} !== 4'b0111) begin
         failures++; $display("FAIL write_grant got=%b exp=0111", {rd_ack, wr_ack, mem_en, mem_we});
      end
      checks++;
      if (mem_addr !== 7'd127) begin failures++; $display("FAIL write_addr got=%0d exp=127", mem_addr); end
      checks++;
      if (mem_wdata !== 24'hFF0000) begin failures++; $display("FAIL write_data got=%h exp=ff0000", mem_wdata); end
      @(negedge clk);
      checks++;
      if ({wr_ack, mem_en} !== 2'b00) begin failures++; $display("FAIL write_pulse got=%b exp=00", {wr_ack, mem_en}); end
   endtask
   task automatic test_arbitration();
      logic exp_wr;
      @(posedge clk); #1 rd_req = 1; wr_req = 1; rd_addr = 6'd3; wr_addr = 6'd10; wr_data = 24'h0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         @(negedge clk);
         exp_wr = GUARD && (i % (SM + 1) == SM);
         checks++;
         if ({rd_ack, wr_ack} !== {!exp_wr, exp_wr}) begin
            failures++; $display("FAIL contest_%0d got=%b exp=%b", i, {rd_ack, wr_ack}, {!exp_wr, exp_wr});
         end
      end
      @(posedge clk); #1 idle_inputs();
      repeat (2) @(posedge clk);
   endtask
   task automatic test_swap();
      @(posedge clk); #1 wr_commit = 1;
      @(posedge clk); #1 wr_commit = 0;
      repeat (99) @(posedge clk);
      #1;
      checks++;
      if (front_bank !== 1'b0) begin failures++; $display("FAIL swap_early got=%b exp=0", front_bank); end
      frame_done = 1;
      @(posedge clk); #1 frame_done = 0;
      checks++;
      if (front_bank !== 1'b1) begin failures++; $display("FAIL swap_toggle got=%b exp=1", front_bank); end
      frame_done = 1;
      @(posedge clk); #1 frame_done = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (front_bank !== 1'b1) begin failures++; $display("FAIL swap_nocommit got=%b exp=1", front_bank); end
   endtask
   task automatic test_swap_same_cycle();
      @(posedge clk); #1 rd_req = 1; rd_addr = 6'd9;
      @(posedge clk); #1 rd_req = 0; wr_commit = 1; frame_done = 1;
      @(negedge clk);
      checks++;
      if ({rd_ack, mem_addr, front_bank} !== {1'b1, 7'd73, 1'b1}) begin
         failures++; $display("FAIL swapcyc_read got ack=%b addr=%0d fb=%b exp ack=1 addr=73 fb=1", rd_ack, mem_addr, front_bank);
      end
      @(posedge clk); #1 wr_commit = 0; frame_done = 0;
      checks++;
      if (front_bank !== 1'b0) begin failures++; $display("FAIL swapcyc_bank got=%b exp=0", front_bank); end
      @(negedge clk);
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, init_pix(73)}) begin
         failures++; $display("FAIL swapcyc_data got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, init_pix(73));
      end
      @(posedge clk); #1 rd_req = 1;
      @(posedge clk); #1 rd_req = 0;
      @(negedge clk);
      checks++;
      if (mem_addr !== 7'd9) begin failures++; $display("FAIL swapcyc_newbank got=%0d exp=9", mem_addr); end
      @(posedge clk); #1;
   endtask
   task automatic test_reset_mid();
      @(posedge clk); #1 wr_commit = 1;
      @(posedge clk); #1 wr_commit = 0; rd_req = 1; rd_addr = 6'd5;
      @(posedge clk); #1 rd_req = 0;
      @(negedge clk); rst = 1;
      #1;
      checks++;
      if ({rd_valid, rd_ack, mem_en} !== 3'b000) begin failures++; $display("FAIL rstmid_async got=%b exp=000", {rd_valid, rd_ack, mem_en}); end
      @(posedge clk); #1;
      checks++;
      if ({rd_valid, front_bank} !== 2'b00) begin failures++; $display("FAIL rstmid_valid got=%b exp=00", {rd_valid, front_bank}); end
      @(negedge clk); rst = 0;
      @(posedge clk); #1 frame_done = 1;
      @(posedge clk); #1 frame_done = 0;
      checks++;
      if ({front_bank, rd_valid, rd_ack} !== 3'b000) begin
         failures++; $display("FAIL rstmid_commit got=%b exp=000", {front_bank, rd_valid, rd_ack});
      end
   endtask
   task automatic test_random();
      int g, ng, cnt;
      logic fb, pend, vld, wwin;
      logic [23:0] rdat, nrdat;
      logic [23:0] er [128];
      logic [6:0] ea;
      @(posedge clk); #1 rst = 1; idle_inputs();
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < 128; i++) er[i] = ram[i];
      g = 0; cnt = 0; fb = 0; pend = 0; vld = 0; rdat = 0;
      for (int n = 0; n < 600; n++) begin
         @(posedge clk); #1;
         rd_req = 1'($urandom % 2); wr_req = ($urandom % 3) != 0;
         rd_addr = 6'($urandom); wr_addr = 6'($urandom); wr_data = 24'($urandom);
         wr_commit = ($urandom % 8) == 0; frame_done = ($urandom % 6) == 0;
         #1;
         ea = (g == 1 && rd_addr < NP) ? 7'(fb * 64 + rd_addr) : (g == 2 && wr_addr < NP) ? 7'((1 - fb) * 64 + wr_addr) : 7'd0;
         checks++;
         if ({rd_ack, wr_ack} !== {g == 1, g == 2}) begin failures++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, {rd_ack, wr_ack}, {g == 1, g == 2}); end
         checks++;
         if ({mem_en, mem_we} !== {ea != 0 || (g == 1 && rd_addr < NP) || (g == 2 && wr_addr < NP), g == 2 && wr_addr < NP}) begin
            failures++; $display("FAIL rnd_en n=%0d got=%b grant=%0d", n, {mem_en, mem_we}, g);
         end
         checks++;
         if (mem_addr !== ea) begin failures++; $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, mem_addr, ea); end
         checks++;
         if (mem_wdata !== ((g == 2 && wr_addr < NP) ? wr_data : 24'h0)) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h", n, mem_wdata); end
         checks++;
         if ({rd_valid, rd_data} !== {vld, rdat}) begin failures++; $display("FAIL rnd_rdata n=%0d got v=%b d=%h exp v=%b d=%h", n, rd_valid, rd_data, vld, rdat); end
         checks++;
         if (front_bank !== fb) begin failures++; $display("FAIL rnd_bank n=%0d got=%b exp=%b", n, front_bank, fb); end
         nrdat = (g == 1 && rd_addr < NP) ? er[fb * 64 + rd_addr] : 24'h0;
         if (g == 2 && wr_addr < NP) er[(1 - fb) * 64 + wr_addr] = wr_data;
         wwin = wr_req && (!rd_req || (GUARD && cnt >= SM));
         ng = wwin ? 2 : rd_req ? 1 : 0;
         cnt = (!wr_req || ng == 2) ? 0 : (ng == 1) ? cnt + 1 : cnt;
         if (frame_done && (pend || wr_commit)) begin fb = !fb; pend = 0; end
         else pend = pend || wr_commit;
         vld = g == 1; rdat = nrdat; g = ng;
      end
      @(posedge clk); #1 idle_inputs();
   endtask
   initial begin
      idle_inputs();
      test_reset();
      test_read();
      test_write();
      test_arbitration();
      test_swap();
      test_swap_same_cycle();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pixel_mem_arbiter.md
PIXEL_MEM_ARBITER -- requirements
Module: pixel_mem_arbiter

Interface
REQ-001 Parameter NUM_PIXELS, 64, pixels per frame buffer bank.
REQ-002 Parameter PIXEL_W, 24, bits per pixel (GRB).
REQ-003 Parameter STARVE_MAX, 4, maximum consecutive read grants while a write is pending.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 rd_req  in  1  display readout request; held until rd_ack.
REQ-007 rd_addr  in  6  pixel index to read from the front bank.
REQ-008 rd_ack  out  1  one-cycle grant pulse for rd_req.
REQ-009 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-010 rd_data  out  PIXEL_W  pixel read from the front bank.
REQ-011 wr_req  in  1  pattern-update write request; held until wr_ack.
REQ-012 wr_addr  in  6  pixel index to write in the back bank.
REQ-013 wr_data  in  PIXEL_W  pixel value to write.
REQ-014 wr_ack  out  1  one-cycle grant pulse for wr_req.
REQ-015 wr_commit  in  1  pulse: back bank complete, swap requested.
REQ-016 frame_done  in  1  pulse: display finished the last pixel of a frame.
REQ-017 mem_en, mem_we  out  1 each  single-port RAM enable and write enable.
REQ-018 mem_addr  out  7  {bank, pixel index}; mem_wdata out PIXEL_W; mem_rdata in PIXEL_W, 1-cycle read latency.
REQ-019 front_bank  out  1  bank currently displayed; back bank = ~front_bank.

Function
REQ-020 FSM states IDLE, RD, WR; each grant state lasts exactly one cycle, then re-arbitrates.
REQ-021 IDLE/RD/WR -> RD when rd_req is set and the read wins; -> WR when wr_req is set and the write wins; else -> IDLE.
REQ-022 Default priority: read wins over write when both are requested in the same cycle.
REQ-023 In RD: mem_en=1, mem_we=0, mem_addr={front_bank, rd_addr}, rd_ack=1; rd_valid=1 and rd_data=mem_rdata exactly one cycle later.
REQ-024 In WR: mem_en=1, mem_we=1, mem_addr={~front_bank, wr_addr}, mem_wdata=wr_data, wr_ack=1.
REQ-025 At most one of rd_ack and wr_ack SHALL be high in any cycle; mem_en=0 in IDLE.
REQ-026 wr_commit sets swap_pending; swap_pending is cleared only by a swap.
REQ-027 Swap: when frame_done=1 and (swap_pending or wr_commit in the same cycle), front_bank toggles on that edge.
REQ-028 frame_done without a pending commit: front_bank unchanged; the same frame is redisplayed.
REQ-029 A wr_commit while swap_pending is already set is absorbed: one swap only.
REQ-030 A read granted in the swap cycle uses the pre-swap front_bank; grants from the next cycle onward use the new bank.
REQ-031 rd_addr/wr_addr >= NUM_PIXELS: the request is acked with no memory access (mem_en=0); a read returns rd_valid with rd_data=0.

Reset
REQ-032 On rst: state=IDLE, front_bank=0, swap_pending=0, starve count=0; rd_ack, wr_ack, rd_valid, mem_en, mem_we=0; rd_data, mem_addr, mem_wdata=0.
REQ-033 Reset mid-operation SHALL suppress any outstanding rd_valid and discard a pending commit; memory contents are untouched.

Configuration
REQ-034 ARB_STARVE_GUARD_EN defined: a counter tracks consecutive read grants while wr_req=1; when it reaches STARVE_MAX, the next contested cycle grants the write and clears the counter.
REQ-035 The counter also clears whenever wr_req=0 or a write is granted.
REQ-036 ARB_STARVE_GUARD_EN undefined: strict read priority; the counter logic is absent.

Structure
REQ-037 Shared package led_pkg holds PIXEL_W, NUM_PIXELS, STARVE_MAX defaults and the enum arb_state_t {IDLE, RD, WR}.
REQ-038 Sub-module arb_starve_guard (counter plus force_write output) is instantiated only under ARB_STARVE_GUARD_EN; the remaining logic is flat.

Verification
REQ-039 rd_req only, rd_addr=5, front_bank=0 -> rd_ack in the grant cycle, mem_addr=7'd5, rd_valid and rd_data=mem_rdata one cycle later.
REQ-040 wr_req, wr_addr=63, wr_data=24'hFF0000, front_bank=0 -> wr_ack, mem_we=1, mem_addr=7'd127, mem_wdata=24'hFF0000.
REQ-041 rd_req and wr_req held together, guard enabled -> pattern RD,RD,RD,RD,WR repeating; guard disabled -> RD only and wr_ack never asserted.
REQ-042 Issue wr_commit, then frame_done 100 cycles later -> front_bank 0->1 at frame_done; a second frame_done with no commit -> front_bank stays 1.
REQ-043 wr_commit and frame_done in the same cycle -> swap on that edge; read granted in that cycle addresses the old bank.
REQ-044 Assert rst one cycle after an RD grant -> rd_valid stays 0, swap_pending=0, front_bank=0, and state is IDLE.
